ps2_cmd_arbiter: RTL and testbench
==================================

Name: ps2_cmd_arbiter

Overview:
- Shares the single PS/2 host transmitter/receiver pair between two command requesters: requester 0 is the mouse init/stream state machine, requester 1 is the microprocessor command port (runtime resolution and sample-rate changes).
- For each granted request it sends the command byte, optionally sends one argument byte, and checks the 0xFA acknowledge for every byte sent.
- It returns a one-cycle done or error pulse to the owning requester.
- It sits between the requesters and the PS/2 transmitter/receiver.

Parameters:
- TIMEOUT_CYCLES, 2500000, cycles allowed in any wait state before abort (50 ms at 50 MHz).
- CNT_W, 22, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.
- MAX_RETRY, 2, resend attempts per byte on a 0xFE response (used only with the optional feature).

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  asynchronous active-low reset.
- REQ  in  2  request per requester; held high until the matching DONE or ERR pulse.
- CMD0, CMD1  in  8  command byte per requester; stable while REQ is high.
- ARG0, ARG1  in  8  argument byte per requester.
- HAS_ARG  in  2  requester sends an argument byte after the command.
- GRANT  out  2  one-hot owner of the current transaction; 0 when idle.
- DONE  out  2  one-cycle pulse: transaction completed with all bytes acknowledged.
- ERR  out  2  one-cycle pulse: transaction aborted.
- BUSY  out  1  high in every state except IDLE.
- SEND_BYTE  out  1  one-cycle pulse to the transmitter.
- BYTE_TO_SEND  out  8  byte presented to the transmitter; held until the next send.
- BYTE_SENT  in  1  transmitter completion pulse.
- READ_ENABLE  out  1  receiver enable; high in the ACK wait states.
- BYTE_READ  in  8  received byte.
- BYTE_ERROR_CODE  in  2  receiver error; 00 means good.
- BYTE_READY  in  1  receiver byte-valid pulse.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE.
  - All outputs 0; BYTE_TO_SEND = 0x00.
  - Round-robin pointer favours requester 0.
  - Retry count and timer cleared.
- Arbitration happens in IDLE only:
  - One requester high: that requester wins.
  - Both high: the requester not served last wins.
  - After reset, requester 0 wins a tie.
  - GRANT is registered, so it is asserted the cycle after IDLE samples REQ.
- States and transitions:
  - IDLE -> SEND_CMD when any REQ is high.
  - SEND_CMD: SEND_BYTE=1 and BYTE_TO_SEND=CMDn for exactly one cycle, then -> WAIT_CMD_SENT.
  - WAIT_CMD_SENT: on BYTE_SENT -> WAIT_CMD_ACK.
  - WAIT_CMD_ACK (READ_ENABLE=1): on BYTE_READY:
    - BYTE_READ 0xFA with code 00, HAS_ARG set -> SEND_ARG.
    - BYTE_READ 0xFA with code 00, HAS_ARG clear -> FINISH_OK.
    - 0xFE -> see Optional Feature.
    - Anything else, or code not 00 -> FINISH_ERR.
  - SEND_ARG, WAIT_ARG_SENT, WAIT_ARG_ACK: same as the three command states, using ARGn.
  - FINISH_OK: DONE[n]=1 for one cycle; GRANT cleared; pointer updated -> IDLE.
  - FINISH_ERR: ERR[n]=1 for one cycle; GRANT cleared; pointer updated -> IDLE.
- Timer:
  - Cleared on entry to every WAIT state; increments each cycle while in one.
  - Reaching TIMEOUT_CYCLES-1 -> FINISH_ERR.
  - Saturates; never wraps.
- Simultaneous events:
  - A BYTE_SENT or BYTE_READY arriving on the timeout cycle wins over the timeout.
  - BYTE_READY outside the ACK states is ignored.
  - BYTE_SENT outside the SENT states is ignored.
- A requester dropping REQ mid-transaction does not abort it; the DONE or ERR pulse is still issued.
- CMDn, ARGn and HAS_ARG are sampled at SEND_CMD and SEND_ARG only.
- Reset asserted mid-transaction returns to IDLE immediately; no DONE or ERR pulse is issued.
- Minimum idle-to-idle latency, excluding transmitter/receiver time: 4 cycles without an argument, 7 with one.

Optional Feature:
- Macro: PS2_ARB_RESEND_RETRY_EN.
- Defined:
  - 0xFE (code 00) in an ACK state returns to the matching SEND state and re-sends the same byte.
  - Retry count increments on each resend.
  - When the count reaches MAX_RETRY, the next 0xFE -> FINISH_ERR.
  - Count clears on each new byte.
- Undefined: 0xFE is treated like any other non-0xFA byte -> FINISH_ERR; MAX_RETRY is unused.

Test Plan:
- Requester 0, CMD0=0xF4, HAS_ARG=0, transmitter acks, receiver returns 0xFA -> exactly one SEND_BYTE with 0xF4; DONE[0] one-cycle pulse; GRANT returns to 00.
- Requester 1, CMD1=0xF3, ARG1=0xC8, HAS_ARG=1, both bytes answered 0xFA -> SEND_BYTE pulses with 0xF3 then 0xC8; DONE[1]; READ_ENABLE high only in the ACK states.
- REQ=11 held for three consecutive transactions after reset -> grants in order 0, 1, 0.
- Command answered 0xFC, then a separate command answered 0xFA with BYTE_ERROR_CODE=01 -> ERR pulse each time, no DONE, FSM back in IDLE.
- TIMEOUT_CYCLES=100, no BYTE_SENT supplied -> ERR exactly 100 cycles after entry to WAIT_CMD_SENT; then RESET_N low mid-wait -> all outputs 0 asynchronously.
- With PS2_ARB_RESEND_RETRY_EN defined and MAX_RETRY=2: three 0xFE responses -> 3 SEND_BYTE pulses of the same byte, then ERR. Two 0xFE responses followed by 0xFA -> DONE. Without the macro: the first 0xFE -> ERR.

Source files
------------

// File: rtl/ps2_cmd_arbiter.sv
// ps2_cmd_arbiter: shares one PS/2 host transmitter/receiver between the mouse
// init/stream FSM (requester 0) and the microprocessor command port
// (requester 1). Each granted transaction sends a command byte, optionally
// one argument byte, and expects a 0xFA acknowledge after every byte.
//
// Build option: define PS2_ARB_RESEND_RETRY_EN to re-send a byte answered
// with 0xFE, up to MAX_RETRY times per byte. Without it 0xFE aborts.
//
// Handshake: SEND_BYTE is a one-cycle strobe with BYTE_TO_SEND valid in the
// same cycle; BYTE_SENT and BYTE_READY are one-cycle completion strobes that
// are only honoured in the matching wait states. REQ is held until the
// owner's DONE or ERR pulse.
module ps2_cmd_arbiter #(
   parameter int TIMEOUT_CYCLES = 2500000,
   parameter int CNT_W          = 22,
   parameter int MAX_RETRY      = 2
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic [1:0] REQ,
   input  logic [7:0] CMD0,
   input  logic [7:0] CMD1,
   input  logic [7:0] ARG0,
   input  logic [7:0] ARG1,
   input  logic [1:0] HAS_ARG,
   output logic [1:0] GRANT,
   output logic [1:0] DONE,
   output logic [1:0] ERR,
   output logic       BUSY,
   output logic       SEND_BYTE,
   output logic [7:0] BYTE_TO_SEND,
   input  logic       BYTE_SENT,
   output logic       READ_ENABLE,
   input  logic [7:0] BYTE_READ,
   input  logic [1:0] BYTE_ERROR_CODE,
   input  logic       BYTE_READY,
   output logic [3:0] DBG_STATE,
   output logic [3:0] DBG_RETRY
);

   typedef enum logic [3:0] {
      IDLE          = 4'd0,
      SEND_CMD      = 4'd1,
      WAIT_CMD_SENT = 4'd2,
      WAIT_CMD_ACK  = 4'd3,
      SEND_ARG      = 4'd4,
      WAIT_ARG_SENT = 4'd5,
      WAIT_ARG_ACK  = 4'd6,
      FINISH_OK     = 4'd7,
      FINISH_ERR    = 4'd8
   } state_t;

`ifdef PS2_ARB_RESEND_RETRY_EN
   localparam bit RESEND_EN = 1'b1;
`else
   localparam bit RESEND_EN = 1'b0;
`endif

   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]       ACK_FA  = 8'hFA;
   localparam logic [7:0]       RESEND_FE = 8'hFE;

   state_t           r_state;
   state_t           w_next;
   logic             r_owner;     // requester currently served
   logic             r_last;      // requester served most recently
   logic             r_has_arg;   // argument flag captured at SEND_CMD
   logic [7:0]       r_byte;      // last byte handed to the transmitter
   logic [CNT_W-1:0] r_timer;
   logic [3:0]       r_retry;

   logic             w_winner;
   logic             w_in_wait;
   logic             w_timeout;
   logic             w_ack_ok;
   logic             w_resend;
   logic [7:0]       w_cmd;
   logic [7:0]       w_arg;
   logic [1:0]       w_owner_oh;

   // Tie goes to whoever was not served last; a lone request always wins.
   assign w_winner   = (REQ == 2'b11) ? ~r_last : REQ[1];
   assign w_cmd      = r_owner ? CMD1 : CMD0;
   assign w_arg      = r_owner ? ARG1 : ARG0;
   assign w_owner_oh = {r_owner, ~r_owner};
   assign w_in_wait  = (r_state == WAIT_CMD_SENT) || (r_state == WAIT_CMD_ACK) ||
                       (r_state == WAIT_ARG_SENT) || (r_state == WAIT_ARG_ACK);
   assign w_timeout  = (r_timer >= TO_LAST);
   assign w_ack_ok   = (BYTE_READ == ACK_FA) && (BYTE_ERROR_CODE == 2'b00);
   assign w_resend   = RESEND_EN && (BYTE_READ == RESEND_FE) &&
                       (BYTE_ERROR_CODE == 2'b00) && (r_retry < 4'(MAX_RETRY));

   // State register.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) r_state <= IDLE;
      else          r_state <= w_next;
   end

   // Next-state logic; transmitter/receiver strobes beat a same-cycle timeout.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:          if (|REQ) w_next = SEND_CMD;
         SEND_CMD:      w_next = WAIT_CMD_SENT;
         WAIT_CMD_SENT: begin
            if (BYTE_SENT)      w_next = WAIT_CMD_ACK;
            else if (w_timeout) w_next = FINISH_ERR;
         end
         WAIT_CMD_ACK: begin
            if (BYTE_READY) begin
               if (w_ack_ok)      w_next = r_has_arg ? SEND_ARG : FINISH_OK;
               else if (w_resend) w_next = SEND_CMD;
               else               w_next = FINISH_ERR;
            end else if (w_timeout) begin
               w_next = FINISH_ERR;
            end
         end
         SEND_ARG:      w_next = WAIT_ARG_SENT;
         WAIT_ARG_SENT: begin
            if (BYTE_SENT)      w_next = WAIT_ARG_ACK;
            else if (w_timeout) w_next = FINISH_ERR;
         end
         WAIT_ARG_ACK: begin
            if (BYTE_READY) begin
               if (w_ack_ok)      w_next = FINISH_OK;
               else if (w_resend) w_next = SEND_ARG;
               else               w_next = FINISH_ERR;
            end else if (w_timeout) begin
               w_next = FINISH_ERR;
            end
         end
         FINISH_OK:     w_next = IDLE;
         FINISH_ERR:    w_next = IDLE;
         default:       w_next = IDLE;
      endcase
   end

   // Ownership, round-robin pointer and captured transaction data.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_owner   <= 1'b0;
         r_last    <= 1'b1;
         r_has_arg <= 1'b0;
         r_byte    <= 8'h00;
      end else begin
         if (r_state == IDLE && (|REQ)) r_owner <= w_winner;
         if (r_state == FINISH_OK || r_state == FINISH_ERR) r_last <= r_owner;
         if (r_state == SEND_CMD) begin
            r_has_arg <= HAS_ARG[r_owner];
            r_byte    <= w_cmd;
         end
         if (r_state == SEND_ARG) r_byte <= w_arg;
      end
   end

   // Wait timer: restarts on every state change, saturates instead of wrapping.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_timer <= '0;
      end else if (w_next != r_state) begin
         r_timer <= '0;
      end else if (w_in_wait && (r_timer != {CNT_W{1'b1}})) begin
         r_timer <= r_timer + 1'b1;
      end
   end

   // Resend counter: counts resends of the current byte, cleared per byte.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_retry <= 4'd0;
      end else if (r_state == IDLE) begin
         r_retry <= 4'd0;
      end else if ((r_state == WAIT_CMD_ACK && w_next == SEND_CMD) ||
                   (r_state == WAIT_ARG_ACK && w_next == SEND_ARG)) begin
         r_retry <= r_retry + 4'd1;
      end else if (r_state == WAIT_CMD_ACK && w_next == SEND_ARG) begin
         r_retry <= 4'd0;
      end
   end

   // Moore outputs decoded from registered state, so reset clears them at once.
   always_comb begin
      GRANT        = 2'b00;
      DONE         = 2'b00;
      ERR          = 2'b00;
      BUSY         = (r_state != IDLE);
      SEND_BYTE    = (r_state == SEND_CMD) || (r_state == SEND_ARG);
      READ_ENABLE  = (r_state == WAIT_CMD_ACK) || (r_state == WAIT_ARG_ACK);
      BYTE_TO_SEND = r_byte;
      if (r_state != IDLE)       GRANT = w_owner_oh;
      if (r_state == FINISH_OK)  DONE  = w_owner_oh;
      if (r_state == FINISH_ERR) ERR   = w_owner_oh;
      if (r_state == SEND_CMD)   BYTE_TO_SEND = w_cmd;
      if (r_state == SEND_ARG)   BYTE_TO_SEND = w_arg;
   end

   assign DBG_STATE = r_state;
   assign DBG_RETRY = r_retry;

endmodule

// File: tb/tb_ps2_cmd_arbiter.sv
// Directed testbench for ps2_cmd_arbiter (timeout shortened to 100 cycles).
module tb_ps2_cmd_arbiter;

   logic       CLK = 1'b0;
   logic       RESET_N = 1'b0;
   logic [1:0] REQ = 2'b00;
   logic [7:0] CMD0 = 8'h00, CMD1 = 8'h00, ARG0 = 8'h00, ARG1 = 8'h00;
   logic [1:0] HAS_ARG = 2'b00;
   logic [1:0] GRANT, DONE, ERR;
   logic       BUSY, SEND_BYTE, READ_ENABLE;
   logic [7:0] BYTE_TO_SEND;
   logic       BYTE_SENT = 1'b0;
   logic [7:0] BYTE_READ = 8'h00;
   logic [1:0] BYTE_ERROR_CODE = 2'b00;
   logic       BYTE_READY = 1'b0;
   logic [3:0] DBG_STATE, DBG_RETRY;

   int n_cmp = 0;
   int n_bad = 0;
   int n_done = 0;
   int n_errp = 0;
   logic [7:0] exp_q[$];

   ps2_cmd_arbiter #(.TIMEOUT_CYCLES(100), .CNT_W(22), .MAX_RETRY(2)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .REQ(REQ),
      .CMD0(CMD0), .CMD1(CMD1), .ARG0(ARG0), .ARG1(ARG1), .HAS_ARG(HAS_ARG),
      .GRANT(GRANT), .DONE(DONE), .ERR(ERR), .BUSY(BUSY),
      .SEND_BYTE(SEND_BYTE), .BYTE_TO_SEND(BYTE_TO_SEND), .BYTE_SENT(BYTE_SENT),
      .READ_ENABLE(READ_ENABLE), .BYTE_READ(BYTE_READ),
      .BYTE_ERROR_CODE(BYTE_ERROR_CODE), .BYTE_READY(BYTE_READY),
      .DBG_STATE(DBG_STATE), .DBG_RETRY(DBG_RETRY)
   );

   // clock / watchdog
   always #5 CLK = ~CLK;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // scoreboard: every transmitter strobe must match the next expected byte
   always @(negedge CLK) begin
      if (RESET_N) begin
         if (SEND_BYTE) begin
            if (exp_q.size() == 0) chk("send_unexpected", exp_q.size(), 1);
            else                   chk("send_byte", BYTE_TO_SEND, exp_q.pop_front());
         end
         if (|DONE) n_done++;
         if (|ERR)  n_errp++;
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RESET_N = 1'b0;
      REQ = 2'b00;
      BYTE_SENT = 1'b0;
      BYTE_READY = 1'b0;
      repeat (2) tick();
      RESET_N = 1'b1;
      tick();
   endtask

   task automatic wait_send(input logic [7:0] b, output int waited);
      int w;
      w = 0;
      exp_q.push_back(b);
      while (!SEND_BYTE && w < 20) begin
         tick();
         w++;
      end
      waited = w;
      chk("send_seen", SEND_BYTE, 1'b1);
   endtask

   // transmitter accepts at once, receiver answers resp/code at once
   task automatic serve(input logic [7:0] b, input logic [7:0] resp, input logic [1:0] code,
                        input logic [1:0] grant, output int waited);
      wait_send(b, waited);
      chk("grant_at_send", GRANT, grant);
      chk("rd_en_in_send", READ_ENABLE, 1'b0);
      tick();
      chk("byte_held", BYTE_TO_SEND, b);
      chk("rd_en_in_wait_sent", READ_ENABLE, 1'b0);
      BYTE_SENT = 1'b1;
      tick();
      BYTE_SENT = 1'b0;
      chk("rd_en_in_ack", READ_ENABLE, 1'b1);
      BYTE_READ = resp;
      BYTE_ERROR_CODE = code;
      BYTE_READY = 1'b1;
      tick();
      BYTE_READY = 1'b0;
      BYTE_READ = 8'h00;
      BYTE_ERROR_CODE = 2'b00;
   endtask

   initial begin
      int w;
      int k;
      int done_before;
      int err_before;

      // reset state
      tick();
      chk("reset_outputs", {GRANT, DONE, ERR, BUSY, SEND_BYTE, READ_ENABLE, BYTE_TO_SEND}, 17'h0);
      RESET_N = 1'b1;
      tick();

      // requester 0, single command 0xF4
      REQ = 2'b01; CMD0 = 8'hF4; HAS_ARG = 2'b00;
      chk("t1_grant_idle", GRANT, 2'b00);
      serve(8'hF4, 8'hFA, 2'b00, 2'b01, w);
      chk("t1_grant_latency", w, 1);
      chk("t1_done", DONE, 2'b01);
      chk("t1_err", ERR, 2'b00);
      REQ = 2'b00;
      tick();
      chk("t1_done_pulse_end", DONE, 2'b00);
      chk("t1_grant_idle_after", GRANT, 2'b00);
      chk("t1_busy_after", BUSY, 1'b0);
      chk("t1_done_count", n_done, 1);

      // requester 1, command 0xF3 with argument 0xC8
      REQ = 2'b10; CMD1 = 8'hF3; ARG1 = 8'hC8; HAS_ARG = 2'b10;
      serve(8'hF3, 8'hFA, 2'b00, 2'b10, w);
      chk("t2_cmd_latency", w, 1);
      serve(8'hC8, 8'hFA, 2'b00, 2'b10, w);
      chk("t2_arg_immediate", w, 0);
      chk("t2_done", DONE, 2'b10);
      REQ = 2'b00;
      tick();
      chk("t2_busy_after", BUSY, 1'b0);
      chk("t2_rd_en_idle", READ_ENABLE, 1'b0);
      chk("t2_done_count", n_done, 2);

      // both requesting after reset: grants 0, 1, 0
      do_reset();
      REQ = 2'b11; CMD0 = 8'hF4; CMD1 = 8'hE8; HAS_ARG = 2'b00;
      for (int i = 0; i < 3; i++) begin
         serve((i == 1) ? 8'hE8 : 8'hF4, 8'hFA, 2'b00, (i == 1) ? 2'b10 : 2'b01, w);
         chk("t3_done", DONE, (i == 1) ? 2'b10 : 2'b01);
         if (i == 2) REQ = 2'b00;
         tick();
      end
      chk("t3_done_count", n_done, 5);
      chk("t3_busy_after", BUSY, 1'b0);

      // bad acknowledge byte, then good byte with receiver error
      REQ = 2'b01; CMD0 = 8'hE6;
      serve(8'hE6, 8'hFC, 2'b00, 2'b01, w);
      chk("t4_err_fc", ERR, 2'b01);
      chk("t4_no_done_fc", DONE, 2'b00);
      REQ = 2'b00;
      tick();
      chk("t4_idle_fc", BUSY, 1'b0);
      REQ = 2'b01;
      serve(8'hE6, 8'hFA, 2'b01, 2'b01, w);
      chk("t4_err_code", ERR, 2'b01);
      chk("t4_no_done_code", DONE, 2'b00);
      REQ = 2'b00;
      tick();
      chk("t4_idle_code", BUSY, 1'b0);
      chk("t4_done_count", n_done, 5);

      // no BYTE_SENT: ERR 100 cycles after entering WAIT_CMD_SENT
      REQ = 2'b10; CMD1 = 8'hF2;
      wait_send(8'hF2, w);
      tick();
      k = 0;
      while (ERR == 2'b00 && k < 200) begin
         tick();
         k++;
      end
      chk("t5_timeout_cycles", k, 100);
      chk("t5_timeout_err", ERR, 2'b10);
      REQ = 2'b00;
      tick();

      // BYTE_SENT on the timeout cycle wins
      REQ = 2'b01; CMD0 = 8'hF4;
      wait_send(8'hF4, w);
      tick();
      repeat (99) tick();
      chk("t5b_still_waiting", ERR, 2'b00);
      BYTE_SENT = 1'b1;
      tick();
      BYTE_SENT = 1'b0;
      chk("t5b_sent_wins", READ_ENABLE, 1'b1);
      chk("t5b_no_err", ERR, 2'b00);
      BYTE_READ = 8'hFA; BYTE_READY = 1'b1;
      tick();
      BYTE_READY = 1'b0;
      chk("t5b_done", DONE, 2'b01);
      REQ = 2'b00;
      tick();

      // reset mid-wait clears outputs asynchronously, no pulse follows
      REQ = 2'b10; CMD1 = 8'hF2;
      wait_send(8'hF2, w);
      repeat (11) tick();
      done_before = n_done;
      err_before = n_errp;
      chk("t5c_busy_before", BUSY, 1'b1);
      #2 RESET_N = 1'b0;
      #1;
      chk("t5c_async_outputs", {GRANT, DONE, ERR, BUSY, SEND_BYTE, READ_ENABLE, BYTE_TO_SEND}, 17'h0);
      REQ = 2'b00;
      tick();
      RESET_N = 1'b1;
      repeat (2) tick();
      chk("t5c_no_err_pulse", n_errp, err_before);
      chk("t5c_no_done_pulse", n_done, done_before);
      chk("t5c_idle", BUSY, 1'b0);

      // 0xFE handling
      REQ = 2'b01; CMD0 = 8'hF3; HAS_ARG = 2'b00;
`ifdef PS2_ARB_RESEND_RETRY_EN
      serve(8'hF3, 8'hFE, 2'b00, 2'b01, w);
      serve(8'hF3, 8'hFE, 2'b00, 2'b01, w);
      chk("t6_resend_immediate", w, 0);
      serve(8'hF3, 8'hFE, 2'b00, 2'b01, w);
      chk("t6_retry_exhausted_err", ERR, 2'b01);
      REQ = 2'b00;
      tick();
      REQ = 2'b01;
      serve(8'hF3, 8'hFE, 2'b00, 2'b01, w);
      serve(8'hF3, 8'hFE, 2'b00, 2'b01, w);
      serve(8'hF3, 8'hFA, 2'b00, 2'b01, w);
      chk("t6_retry_then_done", DONE, 2'b01);
      REQ = 2'b00;
      tick();
`else
      serve(8'hF3, 8'hFE, 2'b00, 2'b01, w);
      chk("t6_fe_err", ERR, 2'b01);
      chk("t6_fe_no_done", DONE, 2'b00);
      REQ = 2'b00;
      tick();
      chk("t6_fe_idle", BUSY, 1'b0);
`endif
      tick();
      chk("exp_q_empty", exp_q.size(), 0);

      // final report
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
